// File: rtl/fcvt_arbiter.sv
// fcvt_arbiter: shares one pipelined float-to-int converter between two
// requesters (A = core FPU issue, B = secondary/vector issue). Round-robin
// issue gated by credits, an id/tag tracking pipe that mirrors the
// converter latency, and a first-word-fall-through response FIFO per
// requester. Credits reserve FIFO space at issue time, so write-back never
// finds a full FIFO and the converter is never stalled.
module fcvt_arbiter #(
    parameter int LATENCY    = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [31:0]      a_x,
    input  logic             a_rm,
    input  logic [TAG_W-1:0] a_tag,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [31:0]      b_x,
    input  logic             b_rm,
    input  logic [TAG_W-1:0] b_tag,
    output logic [31:0]      cvt_x,
    output logic             cvt_rm,
    input  logic [31:0]      cvt_y,
    output logic             ra_valid,
    input  logic             ra_ready,
    output logic [31:0]      ra_y,
    output logic [TAG_W-1:0] ra_tag,
    output logic             rb_valid,
    input  logic             rb_ready,
    output logic [31:0]      rb_y,
    output logic [TAG_W-1:0] rb_tag,
    output logic             busy
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int NSTG  = LATENCY + 1;

    // Per-requester views, index 0 = A, index 1 = B.
    logic [1:0]       req_valid;
    logic [31:0]      req_x   [2];
    logic [1:0]       req_rm;
    logic [TAG_W-1:0] req_tag [2];
    logic [1:0]       rsp_ready;
    logic [1:0]       rsp_valid;
    logic [31:0]      rsp_y   [2];
    logic [TAG_W-1:0] rsp_tag [2];

    logic [CNT_W:0]   used    [2];
    logic [1:0]       eligible;
    logic [1:0]       want;
    logic [1:0]       ready;
    logic [1:0]       grant;
    logic             any_grant;
    logic             grant_id;

    // Round-robin pointer: 0 means A wins a tie.
    logic             ptr_reg;
    logic [31:0]      cvt_x_reg;
    logic             cvt_rm_reg;

    // Tracking pipe, one stage per converter cycle plus the issue register.
    logic [NSTG-1:0]  stg_valid_reg;
    logic [NSTG-1:0]  stg_id_reg;
    logic [TAG_W-1:0] stg_tag_reg [NSTG];

    assign req_valid  = {b_valid, a_valid};
    assign req_x[0]   = a_x;
    assign req_x[1]   = b_x;
    assign req_rm     = {b_rm, a_rm};
    assign req_tag[0] = a_tag;
    assign req_tag[1] = b_tag;
    assign rsp_ready  = {rb_ready, ra_ready};

    assign any_grant = |grant;
    assign grant_id  = grant[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            logic [31:0]      mem_y   [FIFO_DEPTH];
            logic [TAG_W-1:0] mem_tag [FIFO_DEPTH];
            logic [PTR_W-1:0] wr_ptr_reg;
            logic [PTR_W-1:0] rd_ptr_reg;
            logic [CNT_W-1:0] occ_reg;
            logic [CNT_W-1:0] inflight_reg;
            logic             push;
            logic             pop;

            assign push = stg_valid_reg[LATENCY] && (stg_id_reg[LATENCY] == 1'(gi));
            assign pop  = rsp_valid[gi] && rsp_ready[gi];

            // Credits come from registered state only; a same-cycle pop is
            // deliberately not credited back until the next cycle.
            assign used[gi]     = {1'b0, occ_reg} + {1'b0, inflight_reg};
            assign eligible[gi] = used[gi] < (CNT_W + 1)'(FIFO_DEPTH);
            assign want[gi]     = req_valid[gi] && eligible[gi];
            // Ready looks only at the other side's request, never our own.
            assign ready[gi]    = eligible[gi] && (!want[1 - gi] || (ptr_reg == 1'(gi)));
            assign grant[gi]    = want[gi] && ready[gi];

            assign rsp_valid[gi] = (occ_reg != '0);
            assign rsp_y[gi]     = mem_y[rd_ptr_reg];
            assign rsp_tag[gi]   = mem_tag[rd_ptr_reg];

            // Response storage: write-back lands at the tail; no reset needed.
            always_ff @(posedge clk) begin
                if (push) begin
                    mem_y[wr_ptr_reg]   <= cvt_y;
                    mem_tag[wr_ptr_reg] <= stg_tag_reg[LATENCY];
                end
            end

            // FIFO pointers and occupancy; push and pop may share an edge.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    occ_reg    <= '0;
                end else begin
                    if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                    if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                    if (push && !pop)      occ_reg <= occ_reg + CNT_W'(1);
                    else if (pop && !push) occ_reg <= occ_reg - CNT_W'(1);
                end
            end

            // In-flight count: up on issue, down when the result is written back.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    inflight_reg <= '0;
                end else if (grant[gi] && !push) begin
                    inflight_reg <= inflight_reg + CNT_W'(1);
                end else if (push && !grant[gi]) begin
                    inflight_reg <= inflight_reg - CNT_W'(1);
                end
            end
        end
    endgenerate

    // Issue register: capture the granted operand and swing the pointer away
    // from the side just served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cvt_x_reg  <= '0;
            cvt_rm_reg <= 1'b0;
            ptr_reg    <= 1'b0;
        end else if (any_grant) begin
            cvt_x_reg  <= req_x[grant_id];
            cvt_rm_reg <= req_rm[grant_id];
            ptr_reg    <= ~grant_id;
        end
    end

    // Tracking pipe advances every cycle in lockstep with the converter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_valid_reg <= '0;
            stg_id_reg    <= '0;
            for (int i = 0; i < NSTG; i++) begin
                stg_tag_reg[i] <= '0;
            end
        end else begin
            stg_valid_reg[0] <= any_grant;
            stg_id_reg[0]    <= grant_id;
            stg_tag_reg[0]   <= req_tag[grant_id];
            for (int i = 1; i < NSTG; i++) begin
                stg_valid_reg[i] <= stg_valid_reg[i-1];
                stg_id_reg[i]    <= stg_id_reg[i-1];
                stg_tag_reg[i]   <= stg_tag_reg[i-1];
            end
        end
    end

    assign cvt_x    = cvt_x_reg;
    assign cvt_rm   = cvt_rm_reg;
    assign a_ready  = ready[0];
    assign b_ready  = ready[1];
    assign ra_valid = rsp_valid[0];
    assign ra_y     = rsp_y[0];
    assign ra_tag   = rsp_tag[0];
    assign rb_valid = rsp_valid[1];
    assign rb_y     = rsp_y[1];
    assign rb_tag   = rsp_tag[1];
    assign busy     = (|stg_valid_reg) || (|rsp_valid);

endmodule

// File: tb/tb_fcvt_arbiter.sv
// Directed testbench for fcvt_arbiter with a one-stage float-to-int
// converter model standing in for ftoi_d.
module tb_fcvt_arbiter;
    localparam int LATENCY    = 1;
    localparam int FIFO_DEPTH = 4;
    localparam int TAG_W      = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             a_valid, a_ready, a_rm;
    logic [31:0]      a_x;
    logic [TAG_W-1:0] a_tag;
    logic             b_valid, b_ready, b_rm;
    logic [31:0]      b_x;
    logic [TAG_W-1:0] b_tag;
    logic [31:0]      cvt_x, cvt_y;
    logic             cvt_rm;
    logic             ra_valid, ra_ready, rb_valid, rb_ready;
    logic [31:0]      ra_y, rb_y;
    logic [TAG_W-1:0] ra_tag, rb_tag;
    logic             busy;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0]      qa_y[$], qb_y[$];
    logic [TAG_W-1:0] qa_tag[$], qb_tag[$];
    logic [31:0]      a_log[$];
    int  na_acc, nb_acc, na_pop, nb_pop, out_a_max;
    bit  a_fire, b_fire;
    int  ia, ib, last_grant, ncyc, pa, pb, acc_a0, acc_b0;
    bit  both_off;
    logic [31:0] a_vec [6];

    always #5 clk = ~clk;

    fcvt_arbiter #(.LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_x(a_x), .a_rm(a_rm), .a_tag(a_tag),
        .b_valid(b_valid), .b_ready(b_ready), .b_x(b_x), .b_rm(b_rm), .b_tag(b_tag),
        .cvt_x(cvt_x), .cvt_rm(cvt_rm), .cvt_y(cvt_y),
        .ra_valid(ra_valid), .ra_ready(ra_ready), .ra_y(ra_y), .ra_tag(ra_tag),
        .rb_valid(rb_valid), .rb_ready(rb_ready), .rb_y(rb_y), .rb_tag(rb_tag),
        .busy(busy)
    );

    // Reference float->int32: rm 0 truncates, rm 1 floors, out-of-range saturates.
    function automatic logic [31:0] ftoi_ref(input logic [31:0] x, input logic rm);
        logic        s;
        int          e;
        logic [63:0] m, mag, r;
        logic        frac;
        s = x[31];
        e = int'(x[30:23]) - 127;
        m = {40'd0, 1'b1, x[22:0]};
        if (x[30:0] == 31'd0) return 32'd0;
        if (x[30:23] == 8'hFF || e >= 31) return s ? 32'h8000_0000 : 32'h7FFF_FFFF;
        if (e < 0) begin
            mag = 64'd0; frac = 1'b1;
        end else if (e >= 23) begin
            mag = m << (e - 23); frac = 1'b0;
        end else begin
            mag  = m >> (23 - e);
            frac = (m & ((64'd1 << (23 - e)) - 64'd1)) != 64'd0;
        end
        if (s) begin
            if (rm && frac) mag = mag + 64'd1;
            r = -mag;
        end else begin
            r = mag;
        end
        return r[31:0];
    endfunction

    // Converter model: one register stage.
    always @(posedge clk) cvt_y <= ftoi_ref(cvt_x, cvt_rm);

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // One clock: sample handshakes, score pops, record accepts, advance.
    task automatic cycle();
        #1;
        a_fire = a_valid && a_ready;
        b_fire = b_valid && b_ready;
        chk("single_grant", 32'(a_fire && b_fire), 32'd0);
        if (ra_valid && ra_ready) begin
            chk("ra_pending", 32'(qa_y.size() != 0), 32'd1);
            if (qa_y.size() != 0) begin
                chk("ra_y", ra_y, qa_y.pop_front());
                chk("ra_tag", 32'(ra_tag), 32'(qa_tag.pop_front()));
            end
            a_log.push_back(ra_y);
            na_pop++;
        end
        if (rb_valid && rb_ready) begin
            chk("rb_pending", 32'(qb_y.size() != 0), 32'd1);
            if (qb_y.size() != 0) begin
                chk("rb_y", rb_y, qb_y.pop_front());
                chk("rb_tag", 32'(rb_tag), 32'(qb_tag.pop_front()));
            end
            nb_pop++;
        end
        if (a_fire) begin qa_y.push_back(ftoi_ref(a_x, a_rm)); qa_tag.push_back(a_tag); na_acc++; end
        if (b_fire) begin qb_y.push_back(ftoi_ref(b_x, b_rm)); qb_tag.push_back(b_tag); nb_acc++; end
        if (na_acc - na_pop > out_a_max) out_a_max = na_acc - na_pop;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        qa_y.delete(); qb_y.delete(); qa_tag.delete(); qb_tag.delete(); a_log.delete();
        na_acc = 0; nb_acc = 0; na_pop = 0; nb_pop = 0; out_a_max = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0;
        clear_model();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        a_valid = 1'b0; b_valid = 1'b0; ra_ready = 1'b1; rb_ready = 1'b1;
        repeat (6) cycle();
        chk("drain_a_empty", 32'(qa_y.size()), 32'd0);
        chk("drain_b_empty", 32'(qb_y.size()), 32'd0);
        chk("drain_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        a_vec = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
                  32'h4080_0000, 32'h40A0_0000, 32'h40C0_0000};
        rst = 1'b1;
        a_valid = 1'b0; a_x = '0; a_rm = 1'b0; a_tag = '0;
        b_valid = 1'b0; b_x = '0; b_rm = 1'b0; b_tag = '0;
        ra_ready = 1'b0; rb_ready = 1'b0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cvt_x", cvt_x, 32'd0);
        chk("rst_cvt_rm", 32'(cvt_rm), 32'd0);
        chk("rst_ra_valid", 32'(ra_valid), 32'd0);
        chk("rst_rb_valid", 32'(rb_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_a_ready", 32'(a_ready), 32'd1);
        chk("idle_b_ready", 32'(b_ready), 32'd1);

        // Single A beat: pi truncated -> 3, two-cycle latency.
        a_valid = 1'b1; a_x = 32'h4049_0FDB; a_rm = 1'b0; a_tag = 4'd5;
        #1;
        chk("t1_a_ready", 32'(a_ready), 32'd1);
        cycle();
        chk("t1_accept", 32'(a_fire), 32'd1);
        a_valid = 1'b0;
        chk("t1_cvt_x", cvt_x, 32'h4049_0FDB);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_ra_valid_e0", 32'(ra_valid), 32'd0);
        cycle();
        chk("t1_ra_valid_e1", 32'(ra_valid), 32'd0);
        cycle();
        chk("t1_ra_valid_e2", 32'(ra_valid), 32'd1);
        chk("t1_ra_y", ra_y, 32'h0000_0003);
        chk("t1_ra_tag", 32'(ra_tag), 32'd5);
        ra_ready = 1'b1;
        cycle();
        chk("t1_ra_valid_pop", 32'(ra_valid), 32'd0);
        chk("t1_busy_pop", 32'(busy), 32'd0);
        ra_ready = 1'b0;

        // Both requesters right after reset: A first, then B.
        do_reset();
        a_valid = 1'b1; a_x = 32'h3F80_0000; a_rm = 1'b0; a_tag = 4'd1;
        b_valid = 1'b1; b_x = 32'hC020_0000; b_rm = 1'b1; b_tag = 4'd2;
        #1;
        chk("t2_a_ready", 32'(a_ready), 32'd1);
        chk("t2_b_ready", 32'(b_ready), 32'd0);
        cycle();
        chk("t2_a_first", 32'(a_fire), 32'd1);
        chk("t2_cvt_x_a", cvt_x, 32'h3F80_0000);
        a_valid = 1'b0;
        #1;
        chk("t2_b_ready_next", 32'(b_ready), 32'd1);
        cycle();
        chk("t2_b_second", 32'(b_fire), 32'd1);
        chk("t2_cvt_x_b", cvt_x, 32'hC020_0000);
        chk("t2_cvt_rm_b", 32'(cvt_rm), 32'd1);
        b_valid = 1'b0;
        cycle();
        chk("t2_ra_valid", 32'(ra_valid), 32'd1);
        chk("t2_ra_y", ra_y, 32'h0000_0001);
        chk("t2_ra_tag", 32'(ra_tag), 32'd1);
        chk("t2_rb_valid_early", 32'(rb_valid), 32'd0);
        cycle();
        chk("t2_rb_valid", 32'(rb_valid), 32'd1);
        chk("t2_rb_y_floor", rb_y, 32'hFFFF_FFFD);
        chk("t2_rb_tag", 32'(rb_tag), 32'd2);
        ra_ready = 1'b1; rb_ready = 1'b1;
        cycle();
        chk("t2_ra_drained", 32'(ra_valid), 32'd0);
        chk("t2_rb_drained", 32'(rb_valid), 32'd0);
        ra_ready = 1'b0; rb_ready = 1'b0;
        b_valid = 1'b1; b_x = 32'hC020_0000; b_rm = 1'b0; b_tag = 4'd3;
        cycle();
        chk("t2_b_trunc_accept", 32'(b_fire), 32'd1);
        b_valid = 1'b0;
        cycle();
        cycle();
        chk("t2_rb_y_trunc", rb_y, 32'hFFFF_FFFE);
        chk("t2_rb_tag_trunc", 32'(rb_tag), 32'd3);
        rb_ready = 1'b1;
        cycle();
        rb_ready = 1'b0;

        // Saturation at both ends of the int32 range.
        a_valid = 1'b1; a_x = 32'h4F00_0000; a_rm = 1'b0; a_tag = 4'd6;
        b_valid = 1'b1; b_x = 32'hCF80_0000; b_rm = 1'b0; b_tag = 4'd7;
        for (int i = 0; i < 4 && (a_valid || b_valid); i++) begin
            cycle();
            if (a_fire) a_valid = 1'b0;
            if (b_fire) b_valid = 1'b0;
        end
        chk("t3_both_issued", 32'({a_valid, b_valid}), 32'd0);
        cycle();
        cycle();
        chk("t3_ra_valid", 32'(ra_valid), 32'd1);
        chk("t3_ra_sat_pos", ra_y, 32'h7FFF_FFFF);
        chk("t3_ra_tag", 32'(ra_tag), 32'd6);
        chk("t3_rb_valid", 32'(rb_valid), 32'd1);
        chk("t3_rb_sat_neg", rb_y, 32'h8000_0000);
        chk("t3_rb_tag", 32'(rb_tag), 32'd7);
        drain();

        // Backpressure on A while B streams.
        clear_model();
        ra_ready = 1'b0; rb_ready = 1'b1;
        ia = 0;
        a_valid = 1'b1; a_x = a_vec[0]; a_rm = 1'b0; a_tag = 4'd8;
        b_valid = 1'b1; b_x = 32'h4120_0000; b_rm = 1'b0; b_tag = 4'd0;
        acc_a0 = na_acc; acc_b0 = nb_acc;
        repeat (12) begin
            cycle();
            if (a_fire) begin
                ia++;
                if (ia < 6) begin a_x = a_vec[ia]; a_tag = TAG_W'(8 + ia); end
                else a_valid = 1'b0;
            end
            if (b_fire) b_tag = b_tag + 1'b1;
        end
        chk("t4_a_accepts", 32'(na_acc - acc_a0), 32'd4);
        chk("t4_b_accepts", 32'(nb_acc - acc_b0), 32'd8);
        chk("t4_a_ready_low", 32'(a_ready), 32'd0);
        chk("t4_ra_head_valid", 32'(ra_valid), 32'd1);
        chk("t4_ra_head_y", ra_y, 32'h0000_0001);
        chk("t4_ra_head_tag", 32'(ra_tag), 32'd8);
        chk("t4_a_outstanding_max", 32'(out_a_max), 32'(FIFO_DEPTH));
        b_valid = 1'b0;
        ra_ready = 1'b1;
        pa = na_pop;
        for (int i = 0; i < 40 && (na_pop - pa) < 6; i++) begin
            cycle();
            if (a_fire) begin
                ia++;
                if (ia < 6) begin a_x = a_vec[ia]; a_tag = TAG_W'(8 + ia); end
                else a_valid = 1'b0;
            end
        end
        chk("t4_a_total_accepts", 32'(na_acc - acc_a0), 32'd6);
        chk("t4_a_pops", 32'(na_pop - pa), 32'd6);
        for (int k = 0; k < 6; k++) begin
            chk("t4_a_order", (k < a_log.size()) ? a_log[k] : 32'hDEAD_BEEF, 32'(k + 1));
        end
        chk("t4_a_outstanding_bound", 32'(out_a_max), 32'(FIFO_DEPTH));
        drain();

        // Contention: both stream 16 ops each; grants must alternate.
        ra_ready = 1'b1; rb_ready = 1'b1;
        ia = 0; ib = 0;
        a_valid = 1'b1; a_x = 32'h3F80_0000; a_rm = 1'b0; a_tag = 4'd0;
        b_valid = 1'b1; b_x = 32'hBF80_0000; b_rm = 1'b1; b_tag = 4'd0;
        last_grant = -1; ncyc = 0; pa = na_pop; pb = nb_pop;
        for (int c = 0; c < 60 && ((na_pop - pa) + (nb_pop - pb)) < 32; c++) begin
            both_off = a_valid && b_valid;
            cycle();
            ncyc++;
            if (both_off) begin
                chk("t5_one_grant", 32'(a_fire ^ b_fire), 32'd1);
                if (last_grant == 0) chk("t5_alternate_to_b", 32'(b_fire), 32'd1);
                if (last_grant == 1) chk("t5_alternate_to_a", 32'(a_fire), 32'd1);
            end
            if (a_fire) begin
                last_grant = 0; ia++;
                if (ia < 16) begin a_x = 32'h3F80_0000 + (32'(ia) << 23); a_tag = TAG_W'(ia); end
                else a_valid = 1'b0;
            end
            if (b_fire) begin
                last_grant = 1; ib++;
                if (ib < 16) begin b_x = 32'hBF80_0000 + (32'(ib) << 23); b_tag = TAG_W'(ib); end
                else b_valid = 1'b0;
            end
        end
        chk("t5_a_returned", 32'(na_pop - pa), 32'd16);
        chk("t5_b_returned", 32'(nb_pop - pb), 32'd16);
        chk("t5_cycles_bound", 32'(ncyc <= 36), 32'd1);
        chk("t5_last_a_y", a_log[a_log.size() - 1], 32'h0000_8000);
        drain();

        // Reset in the middle of traffic discards everything.
        ra_ready = 1'b0; rb_ready = 1'b0;
        a_valid = 1'b1; a_x = 32'h4049_0FDB; a_rm = 1'b0; a_tag = 4'd1;
        repeat (3) begin
            cycle();
            chk("t6_accept", 32'(a_fire), 32'd1);
            a_tag = a_tag + 1'b1;
        end
        a_valid = 1'b0;
        chk("t6_pre_ra_valid", 32'(ra_valid), 32'd1);
        chk("t6_pre_busy", 32'(busy), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_rst_ra_valid", 32'(ra_valid), 32'd0);
        chk("t6_rst_rb_valid", 32'(rb_valid), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_cvt_x", cvt_x, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        clear_model();
        ra_ready = 1'b1; rb_ready = 1'b1;
        repeat (10) begin
            cycle();
            chk("t6_no_stale_ra", 32'(ra_valid), 32'd0);
            chk("t6_no_stale_rb", 32'(rb_valid), 32'd0);
        end
        chk("t6_busy_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
